// File: rtl/fixed_to_float_converter.sv
// Signed W-bit fixed-point (FRAC fractional bits) to IEEE-754 single, normalized one shift per cycle.
// ACK_FX rises 4+k edges after capture (k = leading zeros of |x|), 3 for zero; held until Begin_FSM_FX drops.
module fixed_to_float_converter #(
  parameter int W    = 32,
  parameter int FRAC = 26
) (
  input  logic         CLK,
  input  logic         RST_FF,
  input  logic         Begin_FSM_FX,
  input  logic [W-1:0] FIXED,
  output logic         ACK_FX,
  output logic         BUSY,
  output logic [31:0]  FLOAT
);

  typedef enum logic [2:0] {IDLE, ABS, NORM, PACK, DONE} state_t;

  // Biased exponent carried by bit W-1 of the magnitude before any shift.
  localparam logic [8:0] EXP_TOP = 9'(127 + W - 1 - FRAC);

  state_t       state_q, state_d;
  logic [W-1:0] operand_q, operand_d;
  logic [W-1:0] mag_q, mag_d;
  logic         sign_q, sign_d;
  logic         zero_q, zero_d;
  logic [8:0]   exp_q, exp_d;
  logic [31:0]  float_q, float_d;
  logic         unused_bits;

  always_ff @(posedge CLK or posedge RST_FF) begin
    if (RST_FF) begin
      state_q   <= IDLE;
      operand_q <= '0;
      mag_q     <= '0;
      sign_q    <= 1'b0;
      zero_q    <= 1'b0;
      exp_q     <= '0;
      float_q   <= '0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      mag_q     <= mag_d;
      sign_q    <= sign_d;
      zero_q    <= zero_d;
      exp_q     <= exp_d;
      float_q   <= float_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    mag_d     = mag_q;
    sign_d    = sign_q;
    zero_d    = zero_q;
    exp_d     = exp_q;
    float_d   = float_q;
    unique case (state_q)
      IDLE: begin
        if (Begin_FSM_FX) begin
          operand_d = FIXED;
          state_d   = ABS;
        end
      end
      ABS: begin
        sign_d  = operand_q[W-1];
        // Most-negative operand wraps to 2^(W-1), which is the correct magnitude.
        mag_d   = operand_q[W-1] ? (~operand_q + W'(1)) : operand_q;
        exp_d   = EXP_TOP;
        zero_d  = (operand_q == '0);
        state_d = (operand_q == '0) ? PACK : NORM;
      end
      NORM: begin
        if (mag_q[W-1]) begin
          state_d = PACK;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 9'd1;
        end
      end
      PACK: begin
        // Hidden bit dropped; bits below the 23-bit mantissa are truncated.
        float_d = zero_q ? 32'h0 : {sign_q, exp_q[7:0], mag_q[W-2 -: 23]};
        state_d = DONE;
      end
      DONE: begin
        if (!Begin_FSM_FX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ACK_FX      = (state_q == DONE);
  assign BUSY        = (state_q == ABS) || (state_q == NORM) || (state_q == PACK);
  assign FLOAT       = float_q;
  assign unused_bits = ^{mag_q, exp_q[8]};

endmodule
